// File: rtl/mod_n_seq_checker_if.sv
// Counter-value stream between a mod-N counter and its checker.
// The master drives a sampled value, the slave consumes it.
interface mod_n_seq_checker_if #(
    parameter int CW = 8
) ();

    logic [CW-1:0] cnt_in;
    logic          cnt_vld;

    modport master (
        output cnt_in,
        output cnt_vld
    );

    modport slave (
        input cnt_in,
        input cnt_vld
    );

endinterface

// File: rtl/mod_n_seq_checker.sv
// Receive-side mod-N sequence checker: locks onto 0..MOD-1 and counts errors and wraps.
// Optional 7-segment decode of the last in-range sample when SEG7_DECODE_EN is defined.
module mod_n_seq_checker #(
    parameter int MOD      = 10,
    parameter int CW       = 8,
    parameter int SW       = 8,
    parameter int LOCK_CNT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    mod_n_seq_checker_if.slave    stream,
    output logic                  locked,
    output logic [CW-1:0]         expected,
    output logic                  err_pulse,
    output logic [SW-1:0]         err_cnt,
    output logic                  wrap_pulse,
`ifdef SEG7_DECODE_EN
    output logic [6:0]            seg,
`endif
    output logic [SW-1:0]         wrap_cnt
);

    localparam int MW = $clog2(LOCK_CNT + 1);

    // Values widened by one bit so MOD itself is representable.
    localparam logic [CW:0]   MODV  = (CW + 1)'(MOD);
    localparam logic [CW:0]   LAST  = (CW + 1)'(MOD - 1);
    localparam logic [CW:0]   ONE_W = (CW + 1)'(1);
    localparam logic [MW-1:0] LOCKV = MW'(LOCK_CNT);
    localparam logic [MW-1:0] ONE_M = MW'(1);
    localparam logic [SW-1:0] ONE_S = SW'(1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [MW-1:0] match;
    logic [MW-1:0] match_n;
    logic          miss;
    logic          miss_n;
    logic [CW-1:0] exp_n;
    logic          ep_n;
    logic          wp_n;
    logic [SW-1:0] err_cnt_n;
    logic [SW-1:0] wrap_cnt_n;

    logic [CW:0]   wide_in;
    logic          in_range;
    logic          hit;
    logic          is_last;
    logic [CW-1:0] succ;

    // Successor in the mod-N sequence; done one bit wider so MOD-1+1 cannot overflow.
    function automatic logic [CW-1:0] nxt(input logic [CW-1:0] v);
        logic [CW:0] w;
        w = {1'b0, v};
        if (w == LAST) begin
            w = '0;
        end else begin
            w = w + ONE_W;
        end
        return w[CW-1:0];
    endfunction

    // Per-sample classification terms.
    always_comb begin
        wide_in  = {1'b0, stream.cnt_in};
        in_range = wide_in < MODV;
        hit      = stream.cnt_vld && (stream.cnt_in == expected);
        is_last  = wide_in == LAST;
        succ     = nxt(stream.cnt_in);
    end

    // State and registered outputs; reset aborts everything at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= HUNT;
            match      <= '0;
            miss       <= 1'b0;
            expected   <= '0;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            err_cnt    <= '0;
            wrap_cnt   <= '0;
        end else begin
            state      <= state_n;
            match      <= match_n;
            miss       <= miss_n;
            expected   <= exp_n;
            err_pulse  <= ep_n;
            wrap_pulse <= wp_n;
            err_cnt    <= err_cnt_n;
            wrap_cnt   <= wrap_cnt_n;
        end
    end

    // Next-state: hunt for a seed, confirm it, then track with one-miss tolerance.
    always_comb begin
        state_n = state;
        match_n = match;
        miss_n  = miss;
        exp_n   = expected;
        if (stream.cnt_vld) begin
            unique case (state)
                HUNT: begin
                    if (in_range) begin
                        exp_n   = succ;
                        match_n = ONE_M;
                        state_n = SYNC;
                    end
                end
                SYNC: begin
                    if (hit) begin
                        exp_n   = succ;
                        match_n = match + ONE_M;
                        if (match + ONE_M == LOCKV) begin
                            state_n = LOCKED;
                        end
                    end else if (in_range) begin
                        exp_n   = succ;
                        match_n = ONE_M;
                    end else begin
                        match_n = '0;
                        state_n = HUNT;
                    end
                end
                LOCKED: begin
                    if (hit) begin
                        exp_n  = succ;
                        miss_n = 1'b0;
                    end else begin
                        if (in_range) begin
                            exp_n = succ;
                        end
                        if (miss) begin
                            state_n = HUNT;
                            match_n = '0;
                            miss_n  = 1'b0;
                        end else begin
                            miss_n = 1'b1;
                        end
                    end
                end
                default: begin
                    state_n = HUNT;
                    match_n = '0;
                    miss_n  = 1'b0;
                end
            endcase
        end
    end

    // Outputs: lock flag plus pulse/statistics updates, only while locked.
    always_comb begin
        locked     = state == LOCKED;
        ep_n       = 1'b0;
        wp_n       = 1'b0;
        err_cnt_n  = err_cnt;
        wrap_cnt_n = wrap_cnt;
        if (stream.cnt_vld && state == LOCKED) begin
            if (hit) begin
                if (is_last) begin
                    wp_n       = 1'b1;
                    wrap_cnt_n = wrap_cnt + ONE_S;
                end
            end else begin
                ep_n = 1'b1;
                if (err_cnt != '1) begin
                    err_cnt_n = err_cnt + ONE_S;
                end
            end
        end
    end

`ifdef SEG7_DECODE_EN
    logic [6:0] seg_n;

    // Digit to gfedcba segments; anything past 9 is blank.
    always_comb begin
        seg_n = seg;
        if (stream.cnt_vld && in_range) begin
            unique case (stream.cnt_in[3:0])
                4'd0:    seg_n = 7'b0111111;
                4'd1:    seg_n = 7'b0000110;
                4'd2:    seg_n = 7'b1011011;
                4'd3:    seg_n = 7'b1001111;
                4'd4:    seg_n = 7'b1100110;
                4'd5:    seg_n = 7'b1101101;
                4'd6:    seg_n = 7'b1111101;
                4'd7:    seg_n = 7'b0000111;
                4'd8:    seg_n = 7'b1111111;
                4'd9:    seg_n = 7'b1101111;
                default: seg_n = 7'b0000000;
            endcase
        end
    end

    // Hold the decode of the last valid in-range sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg <= 7'b0111111;
        end else begin
            seg <= seg_n;
        end
    end
`endif

endmodule

// File: tb/tb_mod_n_seq_checker.sv
// Bench for mod_n_seq_checker: directed plan steps plus random stream vs a reference model.
// A second instance with SW=2 shows err_cnt saturation and wrap_cnt rollover.
module tb_mod_n_seq_checker;

    localparam int MOD  = 10;
    localparam int CW   = 8;
    localparam int LOCK = 3;

    logic clk;
    logic rst;

    mod_n_seq_checker_if #(.CW(CW)) bus ();

    logic          locked_a;
    logic [CW-1:0] expected_a;
    logic          err_pulse_a;
    logic [7:0]    err_cnt_a;
    logic          wrap_pulse_a;
    logic [7:0]    wrap_cnt_a;

    logic          locked_b;
    logic [CW-1:0] expected_b;
    logic          err_pulse_b;
    logic [1:0]    err_cnt_b;
    logic          wrap_pulse_b;
    logic [1:0]    wrap_cnt_b;

`ifdef SEG7_DECODE_EN
    logic [6:0] seg_a;
    logic [6:0] seg_b;
`endif

    mod_n_seq_checker #(.MOD(MOD), .CW(CW), .SW(8), .LOCK_CNT(LOCK)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .stream     (bus.slave),
        .locked     (locked_a),
        .expected   (expected_a),
        .err_pulse  (err_pulse_a),
        .err_cnt    (err_cnt_a),
        .wrap_pulse (wrap_pulse_a),
`ifdef SEG7_DECODE_EN
        .seg        (seg_a),
`endif
        .wrap_cnt   (wrap_cnt_a)
    );

    mod_n_seq_checker #(.MOD(MOD), .CW(CW), .SW(2), .LOCK_CNT(LOCK)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .stream     (bus.slave),
        .locked     (locked_b),
        .expected   (expected_b),
        .err_pulse  (err_pulse_b),
        .err_cnt    (err_cnt_b),
        .wrap_pulse (wrap_pulse_b),
`ifdef SEG7_DECODE_EN
        .seg        (seg_b),
`endif
        .wrap_cnt   (wrap_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: tracks the run of consecutive correct samples.
    bit m_lock;
    int m_run;
    bit m_miss;
    int m_exp;
    int m_err;
    int m_wrap;
    bit m_ep;
    bit m_wp;
    int m_seg;

    int seg_tab [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66,
                         'h6D, 'h7D, 'h07, 'h7F, 'h6F};

    function automatic int succ(input int v);
        return (v == MOD - 1) ? 0 : v + 1;
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_reset();
        m_lock = 0; m_run = 0; m_miss = 0; m_exp = 0;
        m_err = 0; m_wrap = 0; m_ep = 0; m_wp = 0;
        m_seg = 'h3F;
    endtask

    task automatic model_step(input bit v, input int x);
        bit inr;
        m_ep = 0;
        m_wp = 0;
        if (!v) return;
        inr = x < MOD;
        if (m_lock) begin
            if (x == m_exp) begin
                m_exp  = succ(x);
                m_miss = 0;
                if (x == MOD - 1) begin
                    m_wp = 1;
                    m_wrap++;
                end
            end else begin
                m_ep = 1;
                m_err++;
                if (inr) m_exp = succ(x);
                if (m_miss) begin
                    m_lock = 0; m_run = 0; m_miss = 0;
                end else begin
                    m_miss = 1;
                end
            end
        end else if (m_run > 0 && x == m_exp) begin
            m_run++;
            m_exp = succ(x);
            if (m_run >= LOCK) m_lock = 1;
        end else if (inr) begin
            m_run = 1;
            m_exp = succ(x);
        end else begin
            m_run = 0;
        end
        if (inr) m_seg = seg_tab[x];
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic check_all();
        chk("locked",     {31'd0, locked_a},      m_lock);
        chk("expected",   {24'd0, expected_a},    m_exp);
        chk("err_pulse",  {31'd0, err_pulse_a},   m_ep);
        chk("wrap_pulse", {31'd0, wrap_pulse_a},  m_wp);
        chk("err_cnt",    {24'd0, err_cnt_a},     sat(m_err, 255));
        chk("wrap_cnt",   {24'd0, wrap_cnt_a},    m_wrap % 256);
        chk("b_locked",   {31'd0, locked_b},      m_lock);
        chk("b_err_cnt",  {30'd0, err_cnt_b},     sat(m_err, 3));
        chk("b_wrap_cnt", {30'd0, wrap_cnt_b},    m_wrap % 4);
`ifdef SEG7_DECODE_EN
        chk("seg",        {25'd0, seg_a},         m_seg);
`endif
    endtask

    // One sampled cycle: drive, clock, advance model, compare just after the edge.
    task automatic cyc(input bit v, input int x);
        bus.cnt_vld = v;
        bus.cnt_in  = x[CW-1:0];
        @(posedge clk);
        model_step(v, x);
        #1;
        check_all();
    endtask

    task automatic feed(input int x);
        cyc(1'b1, x);
    endtask

    initial begin
        bit v;
        int x;
        rst         = 1'b0;
        bus.cnt_vld = 1'b0;
        bus.cnt_in  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;

        // Idle: no valid samples.
        repeat (20) cyc(1'b0, 0);

        // Lock and wrap.
        for (int i = 0; i < 10; i++) feed(i);
        chk("wrap_once", {24'd0, wrap_cnt_a}, 1);
        feed(0);
        feed(1);

        // Single glitch: 7 in place of 4.
        feed(2); feed(3); feed(7);
        chk("glitch_ep", {31'd0, err_pulse_a}, 1);
        feed(8); feed(9); feed(0);
        chk("glitch_lock", {31'd0, locked_a}, 1);

        // Loss of lock then re-lock.
        feed(1); feed(2); feed(3); feed(3); feed(3);
        chk("lost_lock", {31'd0, locked_a}, 0);
        chk("lost_errs", {24'd0, err_cnt_a}, 3);
        feed(4); feed(5); feed(6);
        chk("relock", {31'd0, locked_a}, 1);

        // Gaps in cnt_vld.
        feed(7);
        cyc(1'b0, 2);
        cyc(1'b0, 5);
        feed(8); feed(9); feed(0);

        // Asynchronous reset between edges.
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        #2;
        rst = 1'b1;

        // Lock, then five single misses between matches.
        for (int i = 0; i < 4; i++) feed(i);
        for (int k = 0; k < 5; k++) begin
            feed((m_exp + 3) % MOD);
            feed(m_exp);
        end
        chk("sat_b", {30'd0, err_cnt_b}, 3);
        feed(m_exp);
        feed(8);
`ifdef SEG7_DECODE_EN
        chk("seg_8", {25'd0, seg_a}, 'h7F);
`endif

        // Random stream, mostly following the sequence.
        for (int n = 0; n < 1500; n++) begin
            v = ($urandom % 4) != 0;
            if (($urandom % 8) != 0) x = m_exp;
            else x = $urandom % (MOD + 3);
            cyc(v, x);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
